// File: rtl/nor_sub_skid.sv
// Elastic stage between normaliser and subnormal handler: 2-entry skid buffer
// with valid/ready handshake, synchronous flush and optional flush-to-zero.
module nor_sub_skid #(
    parameter int MANT_W = 11,
    parameter int EXP_W  = 7,
    parameter int FTZ    = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [MANT_W-1:0] norm_sum_in,
    input  logic [EXP_W-1:0]  exp_final_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [MANT_W-1:0] norm_sum_out,
    output logic [EXP_W-1:0]  exp_final_out,
    output logic [CNT_W-1:0]  ftz_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam bit         FTZ_EN   = (FTZ != 0);

    logic [1:0]        state_q, state_d;
    logic              main_sign_q, main_sign_d;
    logic [MANT_W-1:0] main_sum_q, main_sum_d;
    logic [EXP_W-1:0]  main_exp_q, main_exp_d;
    logic              skid_sign_q, skid_sign_d;
    logic [MANT_W-1:0] skid_sum_q, skid_sum_d;
    logic [EXP_W-1:0]  skid_exp_q, skid_exp_d;
    logic [CNT_W-1:0]  ftz_count_q, ftz_count_d;

    logic              in_fire;
    logic              out_fire;
    logic              is_sub;
    logic [MANT_W-1:0] cap_sum;

    // Ready depends only on registered state, so no out_ready-to-in_ready path.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign is_sub  = FTZ_EN && (exp_final_in == '0) && (norm_sum_in != '0);
    assign cap_sum = is_sub ? '0 : norm_sum_in;

    assign sign_out      = main_sign_q;
    assign norm_sum_out  = main_sum_q;
    assign exp_final_out = main_exp_q;
    assign ftz_count     = ftz_count_q;

    always_comb begin
        state_d     = state_q;
        main_sign_d = main_sign_q;
        main_sum_d  = main_sum_q;
        main_exp_d  = main_exp_q;
        skid_sign_d = skid_sign_q;
        skid_sum_d  = skid_sum_q;
        skid_exp_d  = skid_exp_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_sign_d = 1'b0;
            main_sum_d  = '0;
            main_exp_d  = '0;
            skid_sign_d = 1'b0;
            skid_sum_d  = '0;
            skid_exp_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_sign_d = sign_in;
                        main_sum_d  = cap_sum;
                        main_exp_d  = exp_final_in;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_sign_d = sign_in;
                        main_sum_d  = cap_sum;
                        main_exp_d  = exp_final_in;
                    end else if (in_fire) begin
                        skid_sign_d = sign_in;
                        skid_sum_d  = cap_sum;
                        skid_exp_d  = exp_final_in;
                        state_d     = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_sign_d = skid_sign_q;
                        main_sum_d  = skid_sum_q;
                        main_exp_d  = skid_exp_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // A word discarded by flush never counts as a flush-to-zero event.
    always_comb begin
        ftz_count_d = ftz_count_q;
        if (!flush && in_fire && is_sub && (ftz_count_q != '1)) begin
            ftz_count_d = ftz_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_sign_q <= 1'b0;
            main_sum_q  <= '0;
            main_exp_q  <= '0;
            skid_sign_q <= 1'b0;
            skid_sum_q  <= '0;
            skid_exp_q  <= '0;
            ftz_count_q <= '0;
        end else begin
            state_q     <= state_d;
            main_sign_q <= main_sign_d;
            main_sum_q  <= main_sum_d;
            main_exp_q  <= main_exp_d;
            skid_sign_q <= skid_sign_d;
            skid_sum_q  <= skid_sum_d;
            skid_exp_q  <= skid_exp_d;
            ftz_count_q <= ftz_count_d;
        end
    end

endmodule

// File: tb/tb_nor_sub_skid.sv
// Bench for nor_sub_skid: three instances (FTZ with 2-bit counter, FTZ with
// 16-bit counter, pass-through) compared against a queue-based reference.
module tb_nor_sub_skid;

    localparam int MW = 11;
    localparam int EW = 7;
    localparam int WW = 1 + MW + EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic          sign_in;
    logic [MW-1:0] norm_sum_in;
    logic [EW-1:0] exp_final_in;

    logic          in_ready_a, out_valid_a, sign_out_a;
    logic [MW-1:0] sum_a;
    logic [EW-1:0] exp_a;
    logic [1:0]    cnt_a;
    logic          in_ready_b, out_valid_b, sign_out_b;
    logic [MW-1:0] sum_b;
    logic [EW-1:0] exp_b;
    logic [15:0]   cnt_b;
    logic          in_ready_c, out_valid_c, sign_out_c;
    logic [MW-1:0] sum_c;
    logic [EW-1:0] exp_c;
    logic [15:0]   cnt_c;

    nor_sub_skid #(.MANT_W(MW), .EXP_W(EW), .FTZ(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .sign_in(sign_in), .norm_sum_in(norm_sum_in), .exp_final_in(exp_final_in),
        .out_valid(out_valid_a), .out_ready(out_ready), .sign_out(sign_out_a),
        .norm_sum_out(sum_a), .exp_final_out(exp_a), .ftz_count(cnt_a));

    nor_sub_skid #(.MANT_W(MW), .EXP_W(EW), .FTZ(1), .CNT_W(16)) u_ftz (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .sign_in(sign_in), .norm_sum_in(norm_sum_in), .exp_final_in(exp_final_in),
        .out_valid(out_valid_b), .out_ready(out_ready), .sign_out(sign_out_b),
        .norm_sum_out(sum_b), .exp_final_out(exp_b), .ftz_count(cnt_b));

    nor_sub_skid #(.MANT_W(MW), .EXP_W(EW), .FTZ(0), .CNT_W(16)) u_pass (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
        .sign_in(sign_in), .norm_sum_in(norm_sum_in), .exp_final_in(exp_final_in),
        .out_valid(out_valid_c), .out_ready(out_ready), .sign_out(sign_out_c),
        .norm_sum_out(sum_c), .exp_final_out(exp_c), .ftz_count(cnt_c));

    always #5 clk = ~clk;

    // Reference: raw accepted words in order, plus event counts.
    logic [WW-1:0] q[$];
    int            cnt_sat = 0;
    int            cnt_full = 0;
    int            checks = 0;
    int            errors = 0;
    logic          acc;
    logic [WW-1:0] w;
    logic          have_word;

    function automatic logic is_sub(input logic [WW-1:0] x);
        return (x[EW-1:0] == '0) && (x[EW+MW-1:EW] != '0);
    endfunction

    function automatic logic [WW-1:0] ftz_of(input logic [WW-1:0] x);
        if (is_sub(x)) return {x[WW-1], {(MW+EW){1'b0}}};
        return x;
    endfunction

    function automatic logic [WW-1:0] mk(input logic s, input int m, input int e);
        return {s, MW'(m), EW'(e)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic ev, er;
        ev = (q.size() > 0);
        er = (q.size() < 2);
        check("ready_sat", 32'(in_ready_a), 32'(er));
        check("ready_ftz", 32'(in_ready_b), 32'(er));
        check("ready_pass", 32'(in_ready_c), 32'(er));
        check("valid_sat", 32'(out_valid_a), 32'(ev));
        check("valid_ftz", 32'(out_valid_b), 32'(ev));
        check("valid_pass", 32'(out_valid_c), 32'(ev));
        if (ev) begin
            check("data_sat", 32'({sign_out_a, sum_a, exp_a}), 32'(ftz_of(q[0])));
            check("data_ftz", 32'({sign_out_b, sum_b, exp_b}), 32'(ftz_of(q[0])));
            check("data_pass", 32'({sign_out_c, sum_c, exp_c}), 32'(q[0]));
        end
        check("count_sat", 32'(cnt_a), 32'(cnt_sat));
        check("count_ftz", 32'(cnt_b), 32'(cnt_full));
        check("count_pass", 32'(cnt_c), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sat"}, 32'({sign_out_a, sum_a, exp_a}), 32'd0);
        check({tag, "_ftz"}, 32'({sign_out_b, sum_b, exp_b}), 32'd0);
        check({tag, "_pass"}, 32'({sign_out_c, sum_c, exp_c}), 32'd0);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step(input logic v, input logic [WW-1:0] x, input logic ordy,
                        input logic fl, output logic accepted);
        logic in_fire, out_fire;
        in_valid = v;
        {sign_in, norm_sum_in, exp_final_in} = x;
        out_ready = ordy;
        flush = fl;
        @(negedge clk);
        check_all();
        @(posedge clk);
        in_fire  = v && (q.size() < 2);
        out_fire = (q.size() > 0) && ordy;
        accepted = in_fire;
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
                q.push_back(x);
                if (is_sub(x)) begin
                    if (cnt_sat < 3) cnt_sat++;
                    if (cnt_full < 65535) cnt_full++;
                end
            end
        end
        #1;
    endtask

    task automatic send(input logic [WW-1:0] x, input logic ordy);
        logic a;
        a = 1'b0;
        for (int k = 0; k < 20 && !a; k++) step(1'b1, x, ordy, 1'b0, a);
        check("send_accept", 32'(a), 32'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, '0, ordy, 1'b0, a);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {sign_in, norm_sum_in, exp_final_in} = '0;
        #2 rst = 1'b0;
        #10;
        check_all();
        check_zero("reset_data");
        @(posedge clk);
        #1 rst = 1'b1;

        // Streaming with out_ready held high.
        for (int i = 0; i < 8; i++) send(mk(1'b0, 'h400 + i, i + 1), 1'b1);
        idle(2, 1'b1);

        // Backpressure: A and B absorbed, C held until release.
        send(mk(1'b0, 'h111, 3), 1'b0);
        send(mk(1'b1, 'h222, 4), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, mk(1'b0, 'h333, 5), 1'b0, 1'b0, acc);
        check("c_held", 32'(acc), 32'd0);
        send(mk(1'b0, 'h333, 5), 1'b1);
        idle(3, 1'b1);

        // Flush-to-zero cases and counter saturation.
        send(mk(1'b1, 'h005, 0), 1'b1);
        idle(1, 1'b1);
        send(mk(1'b0, 'h000, 0), 1'b1);
        idle(1, 1'b1);
        for (int i = 0; i < 5; i++) send(mk(i[0], 'h001 + i, 0), 1'b1);
        idle(2, 1'b1);

        // Flush while FULL with a word offered.
        send(mk(1'b0, 'h0AA, 9), 1'b0);
        send(mk(1'b1, 'h0BB, 0), 1'b0);
        step(1'b1, mk(1'b1, 'h0CC, 0), 1'b0, 1'b1, acc);
        check("flush_valid", 32'(out_valid_b), 32'd0);
        check("flush_ready", 32'(in_ready_b), 32'd1);
        check_zero("flush_data");
        send(mk(1'b0, 'h0DD, 12), 1'b1);
        idle(2, 1'b1);

        // Asynchronous reset while FULL.
        send(mk(1'b0, 'h3A1, 2), 1'b0);
        send(mk(1'b1, 'h2B2, 6), 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        q.delete();
        cnt_sat = 0;
        cnt_full = 0;
        check("arst_valid", 32'({out_valid_a, out_valid_b, out_valid_c}), 32'd0);
        check("arst_ready", 32'({in_ready_a, in_ready_b, in_ready_c}), 32'h7);
        check("arst_cnt", 32'({cnt_a, cnt_b, cnt_c}), 32'd0);
        check_zero("arst_data");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(mk(1'b1, 'h155, 0), 1'b1);
        idle(2, 1'b1);

        // Randomized traffic with occasional flush.
        have_word = 1'b0;
        w = '0;
        for (int i = 0; i < 600; i++) begin
            logic ordy, fl;
            if (!have_word && $urandom_range(0, 3) != 0) begin
                w[WW-1] = 1'($urandom);
                w[EW+MW-1:EW] = ($urandom_range(0, 4) == 0) ? '0 : MW'($urandom);
                w[EW-1:0] = ($urandom_range(0, 2) == 0) ? '0 : EW'($urandom);
                have_word = 1'b1;
            end
            ordy = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 39) == 0);
            step(have_word, w, ordy, fl, acc);
            if (acc) have_word = 1'b0;
        end
        idle(3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
